// File: rtl/frame_buffer_fill_pkg.sv
// Shared constants, fill-state encoding and latched rectangle payload for frame_buffer_fill.
package frame_buffer_fill_pkg;

    localparam int unsigned FB_W       = 160;
    localparam int unsigned FB_H       = 120;
    localparam int unsigned FB_DEPTH   = FB_W * FB_H;
    localparam int unsigned FB_ADDR_W  = 15;
    localparam int unsigned PIX_W      = 4;
    localparam int unsigned VGA_ADDR_W = 19;
    localparam int unsigned X_W        = 8;
    localparam int unsigned Y_W        = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } fill_state_e;

    typedef struct packed {
        logic [X_W-1:0]   x0;
        logic [X_W-1:0]   x1;
        logic [Y_W-1:0]   y1;
        logic [PIX_W-1:0] colour;
    } fill_rect_t;

endpackage

// File: rtl/frame_buffer_fill_ram.sv
// 19200x4 simple dual-port RAM: synchronous write, registered read (old data on collision).
module frame_buffer_fill_ram
    import frame_buffer_fill_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [FB_ADDR_W-1:0]  waddr,
    input  logic [PIX_W-1:0]      wdata,
    input  logic [VGA_ADDR_W-1:0] raddr,
    output logic [PIX_W-1:0]      rdata
);

    logic [PIX_W-1:0] mem [FB_DEPTH];
    logic [PIX_W-1:0] rdata_q;
    logic [PIX_W-1:0] rdata_d;
    logic             raddr_ok;

    assign raddr_ok = (raddr < VGA_ADDR_W'(FB_DEPTH));

    // Out-of-range addresses (VGA blanking wrap) read as black.
    always_comb begin
        rdata_d = '0;
        if (raddr_ok) begin
            rdata_d = mem[raddr[FB_ADDR_W-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/frame_buffer_fill.sv
// 160x120x4 frame buffer with direct write port and rectangle-fill engine.
// Define FB_CLIP_EN to clamp oversize rectangles instead of rejecting them.
module frame_buffer_fill
    import frame_buffer_fill_pkg::*;
(
    input  logic        VGA_CLK,
    input  logic        RESET,
    input  logic [18:0] VGA_ADDR,
    output logic [3:0]  VGA_DATA,
    input  logic        WR_EN,
    input  logic [14:0] WR_ADDR,
    input  logic [3:0]  WR_DATA,
    output logic        WR_READY,
    input  logic        FILL_START,
    input  logic [7:0]  FILL_X0,
    input  logic [7:0]  FILL_X1,
    input  logic [6:0]  FILL_Y0,
    input  logic [6:0]  FILL_Y1,
    input  logic [3:0]  FILL_COLOUR,
    output logic        FILL_BUSY,
    output logic        FILL_DONE
);

    fill_state_e          state_q, state_d;
    fill_rect_t           rect_q, rect_d;
    logic [X_W-1:0]       cur_x_q, cur_x_d;
    logic [Y_W-1:0]       cur_y_q, cur_y_d;
    logic [FB_ADDR_W-1:0] row_base_q, row_base_d;
    logic                 wr_ready_q, wr_ready_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic [X_W-1:0]       x1_lim;
    logic [Y_W-1:0]       y1_lim;
    logic                 rect_ok;
    logic [FB_ADDR_W-1:0] fill_addr;
    logic                 wr_fire;
    logic                 ram_we;
    logic [FB_ADDR_W-1:0] ram_waddr;
    logic [PIX_W-1:0]     ram_wdata;

    // Bounds applied at latch time; rect_ok=0 sends the FSM straight to DONE.
    always_comb begin
`ifdef FB_CLIP_EN
        x1_lim  = (FILL_X1 > X_W'(FB_W - 1)) ? X_W'(FB_W - 1) : FILL_X1;
        y1_lim  = (FILL_Y1 > Y_W'(FB_H - 1)) ? Y_W'(FB_H - 1) : FILL_Y1;
        rect_ok = (FILL_X0 <= x1_lim) && (FILL_Y0 <= y1_lim);
`else
        x1_lim  = FILL_X1;
        y1_lim  = FILL_Y1;
        rect_ok = (FILL_X0 <= FILL_X1) && (FILL_Y0 <= FILL_Y1) &&
                  (FILL_X1 <= X_W'(FB_W - 1)) && (FILL_Y1 <= Y_W'(FB_H - 1));
`endif
    end

    assign fill_addr = row_base_q + FB_ADDR_W'(cur_x_q);
    assign wr_fire   = WR_EN && wr_ready_q && (WR_ADDR < FB_ADDR_W'(FB_DEPTH));

    // Fill owns the write port while active; direct writes only land in IDLE.
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = WR_ADDR;
        ram_wdata = WR_DATA;
        if (state_q == FILL) begin
            ram_we    = 1'b1;
            ram_waddr = fill_addr;
            ram_wdata = rect_q.colour;
        end else if (wr_fire) begin
            ram_we    = 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        rect_d     = rect_q;
        cur_x_d    = cur_x_q;
        cur_y_d    = cur_y_q;
        row_base_d = row_base_q;
        case (state_q)
            IDLE: begin
                if (FILL_START) begin
                    rect_d.x0     = FILL_X0;
                    rect_d.x1     = x1_lim;
                    rect_d.y1     = y1_lim;
                    rect_d.colour = FILL_COLOUR;
                    cur_x_d       = FILL_X0;
                    cur_y_d       = FILL_Y0;
                    row_base_d    = (FB_ADDR_W'(FILL_Y0) << 7) + (FB_ADDR_W'(FILL_Y0) << 5);
                    state_d       = rect_ok ? FILL : DONE;
                end
            end
            FILL: begin
                if (cur_x_q == rect_q.x1) begin
                    if (cur_y_q == rect_q.y1) begin
                        state_d = DONE;
                    end else begin
                        cur_x_d    = rect_q.x0;
                        cur_y_d    = cur_y_q + Y_W'(1);
                        row_base_d = row_base_q + FB_ADDR_W'(FB_W);
                    end
                end else begin
                    cur_x_d = cur_x_q + X_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        wr_ready_d = (state_d == IDLE);
        busy_d     = (state_d == FILL);
        done_d     = (state_d == DONE);
    end

    always_ff @(posedge VGA_CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= IDLE;
            rect_q     <= '0;
            cur_x_q    <= '0;
            cur_y_q    <= '0;
            row_base_q <= '0;
            wr_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rect_q     <= rect_d;
            cur_x_q    <= cur_x_d;
            cur_y_q    <= cur_y_d;
            row_base_q <= row_base_d;
            wr_ready_q <= wr_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    frame_buffer_fill_ram u_ram (
        .clk   (VGA_CLK),
        .rst   (RESET),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (VGA_ADDR),
        .rdata (VGA_DATA)
    );

    assign WR_READY  = wr_ready_q;
    assign FILL_BUSY = busy_q;
    assign FILL_DONE = done_q;

endmodule

// File: tb/tb_frame_buffer_fill.sv
// Randomised self-checking bench for frame_buffer_fill against an array-based pixel model.
module tb_frame_buffer_fill;

    localparam int W     = 160;
    localparam int H     = 120;
    localparam int DEPTH = W * H;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [18:0] vga_addr = '0;
    logic [3:0]  vga_data;
    logic        wr_en = 1'b0;
    logic [14:0] wr_addr = '0;
    logic [3:0]  wr_data = '0;
    logic        wr_ready;
    logic        fill_start = 1'b0;
    logic [7:0]  fill_x0 = '0;
    logic [7:0]  fill_x1 = '0;
    logic [6:0]  fill_y0 = '0;
    logic [6:0]  fill_y1 = '0;
    logic [3:0]  fill_colour = '0;
    logic        fill_busy;
    logic        fill_done;

    int checks = 0;
    int errors = 0;
    int model [DEPTH];

    frame_buffer_fill dut (
        .VGA_CLK     (clk),
        .RESET       (rst),
        .VGA_ADDR    (vga_addr),
        .VGA_DATA    (vga_data),
        .WR_EN       (wr_en),
        .WR_ADDR     (wr_addr),
        .WR_DATA     (wr_data),
        .WR_READY    (wr_ready),
        .FILL_START  (fill_start),
        .FILL_X0     (fill_x0),
        .FILL_X1     (fill_x1),
        .FILL_Y0     (fill_y0),
        .FILL_Y1     (fill_y1),
        .FILL_COLOUR (fill_colour),
        .FILL_BUSY   (fill_busy),
        .FILL_DONE   (fill_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input string tag, input int a, input int exp);
        vga_addr = 19'(a);
        tick();
        check(tag, int'(vga_data), exp);
    endtask

    task automatic wr(input int a, input int d);
        check("wr_ready_idle", int'(wr_ready), 1);
        wr_en   = 1'b1;
        wr_addr = 15'(a);
        wr_data = 4'(d);
        tick();
        wr_en = 1'b0;
        if (a < DEPTH) model[a] = d;
    endtask

    task automatic drive_rect(input int x0, input int x1, input int y0, input int y1, input int c);
        fill_x0     = 8'(x0);
        fill_x1     = 8'(x1);
        fill_y0     = 7'(y0);
        fill_y1     = 7'(y1);
        fill_colour = 4'(c);
    endtask

    // Expected pixel count from the rectangle rules; also paints the model.
    function automatic int paint(input int x0, input int x1, input int y0, input int y1, input int c);
        int  ex1 = x1;
        int  ey1 = y1;
        bit  ok;
`ifdef FB_CLIP_EN
        if (ex1 > W - 1) ex1 = W - 1;
        if (ey1 > H - 1) ey1 = H - 1;
        ok = (x0 <= ex1) && (y0 <= ey1);
`else
        ok = (x0 <= x1) && (y0 <= y1) && (x1 < W) && (y1 < H);
`endif
        if (!ok) return 0;
        for (int y = y0; y <= ey1; y++)
            for (int x = x0; x <= ex1; x++)
                model[y * W + x] = c;
        return (ex1 - x0 + 1) * (ey1 - y0 + 1);
    endfunction

    task automatic run_fill(input string tag, input int x0, input int x1, input int y0, input int y1,
                            input int c, input bit mid_pulse, input bit with_wr, input int wa, input int wd);
        int n;
        int cnt   = 0;
        int dones = 0;
        bit ready_seen = 1'b0;
        drive_rect(x0, x1, y0, y1, c);
        fill_start = 1'b1;
        if (with_wr) begin
            check({tag, "_wr_ready"}, int'(wr_ready), 1);
            wr_en   = 1'b1;
            wr_addr = 15'(wa);
            wr_data = 4'(wd);
            if (wa < DEPTH) model[wa] = wd;
        end
        n = paint(x0, x1, y0, y1, c);
        tick();
        fill_start = 1'b0;
        wr_en      = 1'b0;
        while (fill_busy === 1'b1 && cnt < 25000) begin
            if (wr_ready) ready_seen = 1'b1;
            if (fill_done) dones++;
            if (mid_pulse && cnt == 2) begin
                drive_rect(0, 0, 0, 0, 15 - c);
                fill_start = 1'b1;
            end else begin
                fill_start = 1'b0;
            end
            cnt++;
            tick();
        end
        check({tag, "_cycles"}, cnt, n);
        check({tag, "_ready_low"}, int'(ready_seen), 0);
        check({tag, "_done_early"}, dones, 0);
        check({tag, "_done"}, int'(fill_done), 1);
        check({tag, "_done_ready"}, int'(wr_ready), 0);
        fill_start = mid_pulse;
        tick();
        fill_start = 1'b0;
        check({tag, "_done_one"}, int'(fill_done), 0);
        check({tag, "_idle_busy"}, int'(fill_busy), 0);
        check({tag, "_idle_ready"}, int'(wr_ready), 1);
    endtask

    task automatic sample(input string tag, input int k);
        for (int i = 0; i < k; i++) begin
            int a = int'($urandom_range(0, DEPTH - 1));
            rd(tag, a, model[a]);
        end
    endtask

    initial begin
        int wait_cnt;
        // Reset state
        #2;
        check("rst_vga_data", int'(vga_data), 0);
        check("rst_wr_ready", int'(wr_ready), 0);
        check("rst_busy", int'(fill_busy), 0);
        check("rst_done", int'(fill_done), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("ready_before_edge", int'(wr_ready), 0);
        tick();
        check("ready_first_edge", int'(wr_ready), 1);

        // Direct write and read latency
        wr(161, 4'hA);
        rd("rd_161", 161, 4'hA);
        rd("rd_oob_19200", 19200, 0);
        rd("rd_oob_max", 19'h7FFFF, 0);

        // Full clear
        run_fill("clear", 0, 159, 0, 119, 0, 1'b0, 1'b0, 0, 0);
        sample("post_clear", 40);

        // Read/write collision returns old data
        wr(161, 4'hA);
        vga_addr = 19'd161;
        wr_en = 1'b1; wr_addr = 15'd161; wr_data = 4'h5;
        tick();
        wr_en = 1'b0;
        check("rw_same_old", int'(vga_data), 4'hA);
        model[161] = 5;
        tick();
        check("rw_same_new", int'(vga_data), 5);

        // Directed rectangle
        run_fill("rect", 2, 5, 3, 4, 7, 1'b0, 1'b0, 0, 0);
        for (int a = 481; a <= 486; a++) rd("rect_row3", a, model[a]);
        for (int a = 641; a <= 646; a++) rd("rect_row4", a, model[a]);

        // Empty, mid-fill restart, oversized X1, write+start together
        run_fill("empty", 10, 9, 0, 5, 9, 1'b0, 1'b0, 0, 0);
        run_fill("mid_pulse", 0, 9, 0, 3, 3, 1'b1, 1'b0, 0, 0);
        run_fill("x1_200", 150, 200, 119, 119, 11, 1'b0, 1'b0, 0, 0);
        run_fill("wr_and_start", 30, 33, 10, 11, 6, 1'b0, 1'b1, 10 * W + 31, 14);
        rd("wr_and_start_px", 10 * W + 31, model[10 * W + 31]);
        rd("x1_200_px", 119 * W + 159, model[119 * W + 159]);

        // Dropped out-of-range direct writes and random in-range writes
        for (int i = 0; i < 30; i++) begin
            if (i % 5 == 0) wr(int'($urandom_range(DEPTH, 32767)), int'($urandom_range(0, 15)));
            else            wr(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 15)));
        end

        // Random rectangles, some empty or out of range
        for (int i = 0; i < 16; i++) begin
            int x0 = int'($urandom_range(0, 159));
            int y0 = int'($urandom_range(0, 119));
            int x1 = x0 + int'($urandom_range(0, 29));
            int y1 = y0 + int'($urandom_range(0, 19));
            if (x1 > 255) x1 = 255;
            if (y1 > 127) y1 = 127;
            if (i % 4 == 3) begin
                int t = x0; x0 = x1 + 1; x1 = t;
                if (x0 > 255) x0 = 255;
            end
            run_fill("rand", x0, x1, y0, y1, int'($urandom_range(0, 15)), 1'b0, 1'b0, 0, 0);
            sample("rand_sample", 8);
        end

        // Reset in the middle of a 100-pixel fill
        drive_rect(20, 29, 50, 59, 12);
        fill_start = 1'b1;
        tick();
        fill_start = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        #1;
        check("midrst_busy", int'(fill_busy), 0);
        check("midrst_vga", int'(vga_data), 0);
        check("midrst_ready", int'(wr_ready), 0);
        for (int x = 20; x < 25; x++) model[50 * W + x] = 12;
        @(negedge clk);
        rst = 1'b0;
        wait_cnt = 0;
        tick();
        while (wr_ready !== 1'b1 && wait_cnt < 10) begin
            wait_cnt++;
            tick();
        end
        check("midrst_ready_back", int'(wr_ready), 1);
        check("midrst_idle_busy", int'(fill_busy), 0);

        // Full sweep against the model
        for (int a = 0; a < DEPTH; a++) rd("sweep", a, model[a]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
